song_follower: RTL and testbench



---
 rtl/song_follower.sv | 168 ++++++++++++++++
 tb/tb_song_follower.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_follower.sv
// Play-along sequencer: debounces a one-hot played note, grades it against the
// song ROM entry at idx, and skips notes that are not played within the timeout.
module song_follower #(
  parameter int w_note         = 12,
  parameter int song_len       = 62,
  parameter int w_idx          = $clog2(song_len + 1),
  parameter int hold_cycles    = 1000,
  parameter int timeout_cycles = 50000000,
  parameter int w_cnt          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [w_note-1:0] note_in,
  input  logic [w_note-1:0] song_note,
  output logic [w_idx-1:0]  idx,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic              miss,
  output logic              skip,
  output logic [w_cnt-1:0]  hits,
  output logic [w_cnt-1:0]  misses
);

  localparam int w_hold = $clog2(hold_cycles + 1);
  localparam int w_tmr  = $clog2(timeout_cycles + 1);
  localparam logic [w_hold-1:0] hold_last = w_hold'(hold_cycles - 1);
  localparam logic [w_tmr-1:0]  tmr_last  = w_tmr'(timeout_cycles - 1);
  localparam logic [w_idx-1:0]  idx_last  = w_idx'(song_len - 1);

  typedef enum logic [1:0] {
    st_idle   = 2'd0,
    st_listen = 2'd1,
    st_wait   = 2'd2,
    st_done   = 2'd3
  } state_t;

  function automatic logic is_one_hot(input logic [w_note-1:0] v);
    return (v != {w_note{1'b0}}) && ((v & (v - w_note'(1))) == {w_note{1'b0}});
  endfunction

  function automatic logic [w_cnt-1:0] sat_inc(input logic [w_cnt-1:0] c);
    return (c == {w_cnt{1'b1}}) ? c : c + w_cnt'(1);
  endfunction

  state_t             state_r, state_nxt;
  logic [w_idx-1:0]   idx_r, idx_nxt;
  logic [w_cnt-1:0]   hits_r, hits_nxt, misses_r, misses_nxt;
  logic [w_hold-1:0]  hold_r, hold_nxt;
  logic [w_tmr-1:0]   timer_r, timer_nxt;
  logic [w_note-1:0]  prev_note_r, acc_note_r, acc_nxt;
  logic               busy_r, done_r, hit_r, miss_r, skip_r;
  logic               hit_nxt, miss_nxt, skip_nxt;
  logic               stable_s, accept_s, timeout_s;

  assign stable_s  = is_one_hot(note_in) && (note_in == prev_note_r);
  assign accept_s  = stable_s && (hold_r == hold_last);
  assign timeout_s = (timer_r == tmr_last);

  // Next-state, counter and pulse decisions; start overrides everything.
  always_comb begin
    state_nxt  = state_r;
    idx_nxt    = idx_r;
    hits_nxt   = hits_r;
    misses_nxt = misses_r;
    hold_nxt   = hold_r;
    timer_nxt  = timer_r;
    acc_nxt    = acc_note_r;
    hit_nxt    = 1'b0;
    miss_nxt   = 1'b0;
    skip_nxt   = 1'b0;
    if (start) begin
      state_nxt  = st_listen;
      idx_nxt    = {w_idx{1'b0}};
      hits_nxt   = {w_cnt{1'b0}};
      misses_nxt = {w_cnt{1'b0}};
      hold_nxt   = {w_hold{1'b0}};
      timer_nxt  = {w_tmr{1'b0}};
    end else begin
      case (state_r)
        st_idle: state_nxt = st_idle;
        st_listen: begin
          if (accept_s) begin
            acc_nxt   = note_in;
            timer_nxt = {w_tmr{1'b0}};
            hold_nxt  = {w_hold{1'b0}};
            if (note_in == song_note) begin
              hit_nxt   = 1'b1;
              hits_nxt  = sat_inc(hits_r);
              idx_nxt   = idx_r + w_idx'(1);
              state_nxt = (idx_r == idx_last) ? st_done : st_wait;
            end else begin
              miss_nxt   = 1'b1;
              misses_nxt = sat_inc(misses_r);
              state_nxt  = st_wait;
            end
          end else if (timeout_s) begin
            skip_nxt   = 1'b1;
            misses_nxt = sat_inc(misses_r);
            idx_nxt    = idx_r + w_idx'(1);
            timer_nxt  = {w_tmr{1'b0}};
            hold_nxt   = {w_hold{1'b0}};
            state_nxt  = (idx_r == idx_last) ? st_done : st_listen;
          end else begin
            timer_nxt = timer_r + w_tmr'(1);
            hold_nxt  = stable_s ? hold_r + w_hold'(1) : {w_hold{1'b0}};
          end
        end
        st_wait: begin
          // Timer frozen and hold idle until the accepted note is let go.
          timer_nxt = {w_tmr{1'b0}};
          hold_nxt  = {w_hold{1'b0}};
          if (note_in != acc_note_r) begin
            state_nxt = st_listen;
          end else begin
            state_nxt = st_wait;
          end
        end
        st_done: state_nxt = st_done;
        default: state_nxt = st_idle;
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= st_idle;
      idx_r       <= {w_idx{1'b0}};
      hits_r      <= {w_cnt{1'b0}};
      misses_r    <= {w_cnt{1'b0}};
      hold_r      <= {w_hold{1'b0}};
      timer_r     <= {w_tmr{1'b0}};
      prev_note_r <= {w_note{1'b0}};
      acc_note_r  <= {w_note{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      hit_r       <= 1'b0;
      miss_r      <= 1'b0;
      skip_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      idx_r       <= idx_nxt;
      hits_r      <= hits_nxt;
      misses_r    <= misses_nxt;
      hold_r      <= hold_nxt;
      timer_r     <= timer_nxt;
      prev_note_r <= note_in;
      acc_note_r  <= acc_nxt;
      busy_r      <= (state_nxt == st_listen) || (state_nxt == st_wait);
      done_r      <= (state_nxt == st_done);
      hit_r       <= hit_nxt;
      miss_r      <= miss_nxt;
      skip_r      <= skip_nxt;
    end
  end

  assign idx    = idx_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign hit    = hit_r;
  assign miss   = miss_r;
  assign skip   = skip_r;
  assign hits   = hits_r;
  assign misses = misses_r;

endmodule

// File: tb/tb_song_follower.sv
// Self-checking bench for song_follower: scenario tasks compared cycle by cycle
// against a behavioural play-along model (hold 4, timeout 20, 4-note song).
module tb_song_follower;

  localparam int HOLD = 4;
  localparam int TMO  = 20;
  localparam int LEN  = 4;
  localparam logic [11:0] N_C = 12'h800;
  localparam logic [11:0] N_D = 12'h200;
  localparam logic [11:0] N_E = 12'h080;
  localparam logic [11:0] N_G = 12'h010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] note_in = 12'h000;
  logic [11:0] song_note;
  logic [2:0]  idx;
  logic        busy, done, hit, miss, skip;
  logic [15:0] hits, misses;
  logic [11:0] song [0:3];

  int chk_cnt = 0;
  int pass_cnt = 0;

  // model state
  logic        m_listen, m_wait, m_done, ex_hit, ex_miss, ex_skip;
  int          m_pos, m_hits, m_misses, m_streak, m_age;
  logic [11:0] m_prev, m_held;

  always #5 clk = ~clk;

  assign song_note = (idx < 3'd4) ? song[idx[1:0]] : 12'h000;

  song_follower #(.w_note(12), .song_len(LEN), .hold_cycles(HOLD),
                  .timeout_cycles(TMO), .w_cnt(16)) dut (
    .clk(clk), .rst(rst), .start(start), .note_in(note_in), .song_note(song_note),
    .idx(idx), .busy(busy), .done(done), .hit(hit), .miss(miss), .skip(skip),
    .hits(hits), .misses(misses));

  function automatic logic [39:0] obs();
    return {idx, busy, done, hit, miss, skip, hits, misses};
  endfunction

  function automatic logic [39:0] exp_vec();
    return {3'(m_pos), m_listen | m_wait, m_done, ex_hit, ex_miss, ex_skip,
            16'(m_hits), 16'(m_misses)};
  endfunction

  task automatic model_reset();
    m_listen = 1'b0; m_wait = 1'b0; m_done = 1'b0;
    ex_hit = 1'b0; ex_miss = 1'b0; ex_skip = 1'b0;
    m_pos = 0; m_hits = 0; m_misses = 0; m_streak = 0; m_age = 0;
    m_prev = 12'h000; m_held = 12'h000;
  endtask

  // One clock of the play-along rules: a note is taken once it has matched the
  // previous cycle's note HOLD times in a row; TMO listening cycles skip a note.
  task automatic model_step(input logic s, input logic [11:0] n);
    logic stable;
    int sn, an;
    ex_hit = 1'b0; ex_miss = 1'b0; ex_skip = 1'b0;
    if (s) begin
      m_listen = 1'b1; m_wait = 1'b0; m_done = 1'b0;
      m_pos = 0; m_hits = 0; m_misses = 0; m_streak = 0; m_age = 0;
    end else if (m_listen) begin
      stable = ($countones(n) == 1) && (n == m_prev);
      sn = stable ? m_streak + 1 : 0;
      an = m_age + 1;
      if (stable && sn == HOLD) begin
        m_held = n; m_streak = 0; m_age = 0; m_listen = 1'b0;
        if (n == song[m_pos]) begin
          ex_hit = 1'b1;
          m_hits = (m_hits < 65535) ? m_hits + 1 : m_hits;
          m_pos++;
          if (m_pos == LEN) m_done = 1'b1;
          else m_wait = 1'b1;
        end else begin
          ex_miss = 1'b1;
          m_misses = (m_misses < 65535) ? m_misses + 1 : m_misses;
          m_wait = 1'b1;
        end
      end else if (an == TMO) begin
        ex_skip = 1'b1;
        m_misses = (m_misses < 65535) ? m_misses + 1 : m_misses;
        m_pos++; m_streak = 0; m_age = 0;
        if (m_pos == LEN) begin m_listen = 1'b0; m_done = 1'b1; end
      end else begin
        m_streak = sn; m_age = an;
      end
    end else if (m_wait) begin
      if (n != m_held) begin m_wait = 1'b0; m_listen = 1'b1; end
    end
    m_prev = n;
  endtask

  task automatic cycle(input logic s, input logic [11:0] n);
    start = s; note_in = n;
    @(posedge clk);
    model_step(s, n);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if (obs() !== 40'h0) $display("FAIL reset_hold: got %h want %h", obs(), 40'h0);
    else pass_cnt++;
    rst = 1'b0;
    model_reset();
    cycle(1'b0, 12'h000);
    chk_cnt++;
    if (obs() !== exp_vec()) $display("FAIL reset_idle: got %h want %h", obs(), exp_vec());
    else pass_cnt++;
  endtask

  task automatic test_perfect_play();
    int nhit = 0;
    int idx_ok = 1;
    cycle(1'b1, 12'h000);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 8; c++) begin
        cycle(1'b0, (c < 6) ? song[k] : 12'h000);
        chk_cnt++;
        if (obs() !== exp_vec()) $display("FAIL perfect_cyc n%0d c%0d: got %h want %h", k, c, obs(), exp_vec());
        else pass_cnt++;
        if (hit) begin
          nhit++;
          if (idx != 3'(nhit)) idx_ok = 0;
        end
      end
    end
    chk_cnt++;
    if (nhit != 4 || idx_ok != 1) $display("FAIL perfect_hits: got %0d hits idx_ok %0d want 4 hits idx_ok 1", nhit, idx_ok);
    else pass_cnt++;
    chk_cnt++;
    if ({idx, done, busy, hits, misses} !== {3'd4, 1'b1, 1'b0, 16'd4, 16'd0})
      $display("FAIL perfect_end: got idx %0d done %b busy %b hits %0d misses %0d want 4 1 0 4 0", idx, done, busy, hits, misses);
    else pass_cnt++;
  endtask

  task automatic test_wrong_then_right();
    int dlen = 5 + $urandom_range(0, 3);
    int miss_idx = -1;
    cycle(1'b1, 12'h000);
    for (int c = 0; c < dlen + 2 + 6; c++) begin
      cycle(1'b0, (c < dlen) ? N_D : (c < dlen + 2) ? 12'h000 : N_E);
      chk_cnt++;
      if (obs() !== exp_vec()) $display("FAIL wrong_cyc c%0d: got %h want %h", c, obs(), exp_vec());
      else pass_cnt++;
      if (miss) miss_idx = int'(idx);
    end
    chk_cnt++;
    if (miss_idx != 0 || {idx, hits, misses} !== {3'd1, 16'd1, 16'd1})
      $display("FAIL wrong_end: got miss_idx %0d idx %0d hits %0d misses %0d want 0 1 1 1", miss_idx, idx, hits, misses);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int first_skip = 0;
    cycle(1'b1, 12'h000);
    for (int i = 1; i <= 80; i++) begin
      cycle(1'b0, 12'h000);
      chk_cnt++;
      if (obs() !== exp_vec()) $display("FAIL timeout_cyc i%0d: got %h want %h", i, obs(), exp_vec());
      else pass_cnt++;
      if (skip && first_skip == 0) first_skip = i;
    end
    chk_cnt++;
    if (first_skip != 20) $display("FAIL timeout_first: got cycle %0d want 20", first_skip);
    else pass_cnt++;
    chk_cnt++;
    if ({idx, done, misses} !== {3'd4, 1'b1, 16'd4})
      $display("FAIL timeout_end: got idx %0d done %b misses %0d want 4 1 4", idx, done, misses);
    else pass_cnt++;
  endtask

  task automatic test_filter();
    int pulses = 0;
    int got_hit = 0;
    cycle(1'b1, 12'h000);
    for (int c = 0; c < 13; c++) begin
      cycle(1'b0, (c < 3) ? N_E : (N_E | N_G));
      chk_cnt++;
      if (obs() !== exp_vec()) $display("FAIL filter_cyc c%0d: got %h want %h", c, obs(), exp_vec());
      else pass_cnt++;
      if (hit | miss | skip) pulses++;
    end
    chk_cnt++;
    if (pulses != 0 || idx !== 3'd0) $display("FAIL filter_quiet: got pulses %0d idx %0d want 0 0", pulses, idx);
    else pass_cnt++;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, N_E);
      chk_cnt++;
      if (obs() !== exp_vec()) $display("FAIL filter_clean c%0d: got %h want %h", c, obs(), exp_vec());
      else pass_cnt++;
      if (hit) got_hit++;
    end
    chk_cnt++;
    if (got_hit != 1) $display("FAIL filter_hit: got %0d hits want 1", got_hit);
    else pass_cnt++;
  endtask

  task automatic test_repeat();
    int nhit = 0;
    int nskip = 0;
    song[0] = N_E; song[1] = N_E; song[2] = N_D; song[3] = N_C;
    cycle(1'b1, 12'h000);
    for (int c = 0; c < 30; c++) begin
      cycle(1'b0, N_E);
      chk_cnt++;
      if (obs() !== exp_vec()) $display("FAIL repeat_cyc c%0d: got %h want %h", c, obs(), exp_vec());
      else pass_cnt++;
      if (hit) nhit++;
      if (skip) nskip++;
    end
    chk_cnt++;
    if (nhit != 1 || nskip != 0 || idx !== 3'd1)
      $display("FAIL repeat_held: got hits %0d skips %0d idx %0d want 1 0 1", nhit, nskip, idx);
    else pass_cnt++;
    for (int c = 0; c < 7; c++) begin
      cycle(1'b0, (c == 0) ? 12'h000 : N_E);
      chk_cnt++;
      if (obs() !== exp_vec()) $display("FAIL repeat_rel c%0d: got %h want %h", c, obs(), exp_vec());
      else pass_cnt++;
      if (hit) nhit++;
    end
    chk_cnt++;
    if (nhit != 2 || idx !== 3'd2) $display("FAIL repeat_second: got hits %0d idx %0d want 2 2", nhit, idx);
    else pass_cnt++;
    song[0] = N_E; song[1] = N_G; song[2] = N_D; song[3] = N_C;
  endtask

  task automatic test_restart();
    cycle(1'b1, 12'h000);
    for (int c = 0; c < 16; c++) begin
      cycle(1'b0, (c < 6) ? N_E : (c < 8) ? 12'h000 : (c < 14) ? N_G : 12'h000);
      chk_cnt++;
      if (obs() !== exp_vec()) $display("FAIL restart_play c%0d: got %h want %h", c, obs(), exp_vec());
      else pass_cnt++;
    end
    cycle(1'b1, 12'h000);
    chk_cnt++;
    if ({idx, busy, hits, misses} !== {3'd0, 1'b1, 16'd0, 16'd0})
      $display("FAIL restart_clear: got idx %0d busy %b hits %0d misses %0d want 0 1 0 0", idx, busy, hits, misses);
    else pass_cnt++;
    for (int c = 0; c < 4; c++) cycle(1'b0, N_E);
    cycle(1'b1, N_E);
    chk_cnt++;
    if ({hit, miss, skip, idx} !== {3'b000, 3'd0} || obs() !== exp_vec())
      $display("FAIL restart_tie: got %h want %h", obs(), exp_vec());
    else pass_cnt++;
    cycle(1'b0, N_E);
    cycle(1'b0, N_E);
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if (obs() !== 40'h0) $display("FAIL reset_async: got %h want %h", obs(), 40'h0);
    else pass_cnt++;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (obs() !== 40'h0) $display("FAIL reset_held: got %h want %h", obs(), 40'h0);
    else pass_cnt++;
    #2 rst = 1'b0;
    model_reset();
    cycle(1'b0, N_E);
    chk_cnt++;
    if (obs() !== exp_vec()) $display("FAIL reset_release: got %h want %h", obs(), exp_vec());
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [11:0] one;
    logic [11:0] n;
    int len, kind;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 4; k++) begin
        one = 12'h001;
        song[k] = one << $urandom_range(0, 11);
      end
      cycle(1'b1, 12'h000);
      for (int seg = 0; seg < 40; seg++) begin
        kind = $urandom_range(0, 9);
        one = 12'h001;
        if (kind < 5) n = (m_pos < LEN) ? song[m_pos] : 12'h000;
        else if (kind < 7) n = one << $urandom_range(0, 11);
        else if (kind == 7) n = 12'($urandom_range(0, 4095));
        else n = 12'h000;
        len = $urandom_range(1, 8);
        for (int c = 0; c < len; c++) begin
          cycle(($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0, n);
          chk_cnt++;
          if (obs() !== exp_vec()) $display("FAIL random s%0d seg%0d c%0d: got %h want %h", s, seg, c, obs(), exp_vec());
          else pass_cnt++;
        end
      end
    end
  endtask

  initial begin
    song[0] = N_E; song[1] = N_G; song[2] = N_D; song[3] = N_C;
    model_reset();
    test_reset();
    test_perfect_play();
    test_wrong_then_right();
    test_timeout();
    test_filter();
    test_repeat();
    test_restart();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
